// File: rtl/jtag_host_shifter.sv
// JTAG initiator: shifts 1-32 TMS or TDI bits per command and returns the TDO bits it captured.
// TCK is produced by dividing clk, with CLK_DIV clk cycles per half-period.
module jtag_host_shifter #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_mode,
   input  logic [4:0]  cmd_len,
   input  logic [31:0] cmd_data,
   input  logic        cmd_tms_last,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        tck,
   output logic        tms,
   output logic        tdi,
   input  logic        tdo
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t      state;
   logic        mode;
   logic [4:0]  len;
   logic [31:0] data;
   logic        tms_last;
   logic [31:0] capture;
   logic [4:0]  idx;
   logic [4:0]  next_idx;
   logic [7:0]  div_cnt;
   logic        tdo_meta;
   logic        tdo_s;
   logic        ready_q;

   // Returns {tms, tdi} for bit i of a command.
   function automatic logic [1:0] bit_drive(input logic m, input logic [31:0] d,
                                            input logic [4:0] l, input logic tl,
                                            input logic [4:0] i);
      if (m)
         return {d[i], 1'b0};
      else
         return {((i == l) ? tl : 1'b0), d[i]};
   endfunction

   assign next_idx  = idx + 5'd1;
   assign cmd_ready = ready_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         tdo_meta <= 1'b0;
         tdo_s    <= 1'b0;
      end else begin
         tdo_meta <= tdo;
         tdo_s    <= tdo_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ready_q   <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= 32'd0;
         tck       <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         mode      <= 1'b0;
         len       <= 5'd0;
         data      <= 32'd0;
         tms_last  <= 1'b0;
         capture   <= 32'd0;
         idx       <= 5'd0;
         div_cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  mode       <= cmd_mode;
                  len        <= cmd_len;
                  data       <= cmd_data;
                  tms_last   <= cmd_tms_last;
                  capture    <= 32'd0;
                  idx        <= 5'd0;
                  div_cnt    <= 8'd0;
                  ready_q    <= 1'b0;
                  state      <= LOW;
                  {tms, tdi} <= bit_drive(cmd_mode, cmd_data, cmd_len, cmd_tms_last, 5'd0);
               end
            end
            LOW: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= 8'd0;
                  tck     <= 1'b1;
                  state   <= HIGH;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            HIGH: begin
               // Sampling on the last HIGH cycle gives the synchronizer time to settle after the previous falling edge.
               if (div_cnt == DIV_LAST) begin
                  div_cnt      <= 8'd0;
                  tck          <= 1'b0;
                  capture[idx] <= tdo_s;
                  if (idx == len) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= capture | (32'(tdo_s) << idx);
                     state     <= RESP;
                  end else begin
                     idx        <= next_idx;
                     {tms, tdi} <= bit_drive(mode, data, len, tms_last, next_idx);
                     state      <= LOW;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ready_q   <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
